// File: rtl/pipelined_cla_adder.sv
// Pipelined WIDTH-bit adder/subtractor: NSTAGE registered slices built from 4-bit CLA groups.
// Define CLA_SAT_EN to add the sat port (clamp S to the signed limit on overflow).
module pipelined_cla_adder #(
    parameter int WIDTH  = 32,
    parameter int NSTAGE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             sub,
`ifdef CLA_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             ovf
);

    localparam int SLICE = WIDTH / NSTAGE;
    localparam int NG    = SLICE / 4;

    // Returns {carry_out, sum} for one SLICE-wide chunk.
    function automatic logic [SLICE:0] cla_slice(
        input logic [SLICE-1:0] a,
        input logic [SLICE-1:0] b,
        input logic             cin
    );
        logic [SLICE-1:0] p, g, c;
        logic [NG-1:0]    gp, gg;
        logic [NG:0]      gc;
        logic             term;
        p  = a ^ b;
        g  = a & b;
        gp = '0;
        gg = '0;
        gc = '0;
        c  = '0;
        for (int unsigned i = 0; i < NG; i++) begin
            gp[i] = &p[4*i +: 4];
            gg[i] = g[4*i+3]
                  | (p[4*i+3] & g[4*i+2])
                  | (p[4*i+3] & p[4*i+2] & g[4*i+1])
                  | (p[4*i+3] & p[4*i+2] & p[4*i+1] & g[4*i]);
        end
        // Every group carry is a flat sum of products over all lower groups.
        for (int unsigned i = 0; i <= NG; i++) begin
            term = cin;
            for (int unsigned j = 0; j < i; j++) begin
                term = term & gp[j];
            end
            gc[i] = term;
            for (int unsigned j = 0; j < i; j++) begin
                term = gg[j];
                for (int unsigned m = j + 1; m < i; m++) begin
                    term = term & gp[m];
                end
                gc[i] = gc[i] | term;
            end
        end
        for (int unsigned i = 0; i < NG; i++) begin
            c[4*i]   = gc[i];
            c[4*i+1] = g[4*i] | (p[4*i] & gc[i]);
            c[4*i+2] = g[4*i+1] | (p[4*i+1] & g[4*i]) | (p[4*i+1] & p[4*i] & gc[i]);
            c[4*i+3] = g[4*i+2] | (p[4*i+2] & g[4*i+1]) | (p[4*i+2] & p[4*i+1] & g[4*i])
                     | (p[4*i+2] & p[4*i+1] & p[4*i] & gc[i]);
        end
        return {gc[NG], p ^ c};
    endfunction

    logic [WIDTH-1:0]  b_eff;
    logic              c0;
    logic              sat_in0;
    logic [NSTAGE-1:0] vld;
    logic [NSTAGE-1:0] adv;

    assign b_eff = sub ? ~B : B;
    assign c0    = sub | Cin;
`ifdef CLA_SAT_EN
    assign sat_in0 = sat;
`else
    assign sat_in0 = 1'b0;
`endif

    // A stage moves unless it and every stage after it are full while the output stalls.
    always_comb begin
        logic tail;
        adv  = '0;
        tail = 1'b1;
        for (int unsigned i = 0; i < NSTAGE; i++) begin
            tail = tail & vld[NSTAGE-1-i];
            adv[NSTAGE-1-i] = out_ready | ~tail;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
        end else begin
            if (adv[0]) vld[0] <= in_valid;
            for (int unsigned k = 1; k < NSTAGE; k++) begin
                if (adv[k]) vld[k] <= vld[k-1];
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[NSTAGE-1];

    for (genvar k = 0; k < NSTAGE; k++) begin : stg
        localparam int REM = WIDTH - k * SLICE;

        logic                   v_in;
        logic                   c_in;
        logic                   sat_in;
        logic [REM-1:0]         a_in;
        logic [REM-1:0]         b_in;
        logic [SLICE:0]         add;
        logic [(k+1)*SLICE-1:0] s_full;

        if (k == 0) begin : src
            assign v_in   = in_valid;
            assign c_in   = c0;
            assign sat_in = sat_in0;
            assign a_in   = A;
            assign b_in   = b_eff;
            assign s_full = add[SLICE-1:0];
        end else begin : src
            assign v_in   = vld[k-1];
            assign c_in   = stg[k-1].mid.cy;
            assign sat_in = stg[k-1].mid.sat_r;
            assign a_in   = stg[k-1].mid.a_r;
            assign b_in   = stg[k-1].mid.b_r;
            assign s_full = {add[SLICE-1:0], stg[k-1].mid.s_r};
        end

        assign add = cla_slice(a_in[SLICE-1:0], b_in[SLICE-1:0], c_in);

        if (k < NSTAGE - 1) begin : mid
            logic [REM-SLICE-1:0]   a_r;
            logic [REM-SLICE-1:0]   b_r;
            logic [(k+1)*SLICE-1:0] s_r;
            logic                   cy;
            logic                   sat_r;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_r   <= '0;
                    b_r   <= '0;
                    s_r   <= '0;
                    cy    <= 1'b0;
                    sat_r <= 1'b0;
                end else if (adv[k] && v_in) begin
                    a_r   <= a_in[REM-1:SLICE];
                    b_r   <= b_in[REM-1:SLICE];
                    s_r   <= s_full;
                    cy    <= add[SLICE];
                    sat_r <= sat_in;
                end
            end
        end else begin : fin
            logic             ovf_d;
            logic [WIDTH-1:0] s_d;

            // Carry into the MSB is recovered as a^b^s at that bit.
            assign ovf_d = a_in[SLICE-1] ^ b_in[SLICE-1] ^ s_full[WIDTH-1] ^ add[SLICE];

            always_comb begin
                s_d = s_full;
                if (sat_in && ovf_d) begin
                    s_d = s_full[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    S    <= '0;
                    Cout <= 1'b0;
                    ovf  <= 1'b0;
                end else if (adv[k] && v_in) begin
                    S    <= s_d;
                    Cout <= add[SLICE];
                    ovf  <= ovf_d;
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder: directed and random beats against an arithmetic model.
// Exercises the CLA_SAT_EN saturation path when that macro is defined.
module tb_pipelined_cla_adder;

    localparam int W = 32;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] A = '0;
    logic [W-1:0] B = '0;
    logic         Cin = 1'b0;
    logic         sub = 1'b0;
`ifdef CLA_SAT_EN
    logic         sat = 1'b0;
`endif
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] S;
    logic         Cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   accepts = 0;
    int   outs = 0;
    bit   lat_chk = 1'b1;
    bit   ready_chk = 1'b0;
    logic held = 1'b0;
    logic [W-1:0] held_s;
    logic held_c;
    logic held_v;

    always #5 clk = ~clk;

    pipelined_cla_adder #(
        .WIDTH (W),
        .NSTAGE(N)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Cin      (Cin),
        .sub      (sub),
`ifdef CLA_SAT_EN
        .sat      (sat),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .S        (S),
        .Cout     (Cout),
        .ovf      (ovf)
    );

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb, input logic st);
        exp_t         e;
        logic [W-1:0] be;
        logic [W:0]   t;
        be  = sb ? ~b : b;
        t   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, (sb ? 1'b1 : ci)};
        e.s = t[W-1:0];
        e.c = t[W];
        e.v = (a[W-1] == be[W-1]) && (t[W-1] != a[W-1]);
        if (st && e.v) e.s = t[W-1] ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
        e.cyc = 0;
        return e;
    endfunction

    // One clock: sample outputs, score transfers, then advance past the next rising edge.
    task automatic step();
        exp_t e;
        #1;
        if (ready_chk) chk("in_ready_stream", in_ready, 1);
        if (held) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_S", S, held_s);
            chk("stall_Cout", Cout, held_c);
            chk("stall_ovf", ovf, held_v);
        end
        if (q.size() == 0) chk("no_stray_valid", out_valid, 0);
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            chk("S", S, e.s);
            chk("Cout", Cout, e.c);
            chk("ovf", ovf, e.v);
            if (lat_chk) chk("latency", cyc - e.cyc, N);
            outs++;
        end
        held   = out_valid && !out_ready;
        held_s = S;
        held_c = Cout;
        held_v = ovf;
        if (in_valid && in_ready) begin
`ifdef CLA_SAT_EN
            e = model(A, B, Cin, sub, sat);
`else
            e = model(A, B, Cin, sub, 1'b0);
`endif
            e.cyc = cyc;
            q.push_back(e);
            accepts++;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic beat(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sb);
        in_valid = 1'b1;
        A = a;
        B = b;
        Cin = ci;
        sub = sb;
        step();
    endtask

    initial begin
        int a0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_S", S, 0);
        chk("rst_Cout", Cout, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        out_ready = 1'b1;
        beat(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
        step();

        beat(32'h5, 32'h7, 1'b1, 1'b1);
        beat(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        in_valid = 1'b0;
        drain();

        ready_chk = 1'b1;
        for (int i = 0; i < 100; i++) begin
`ifdef CLA_SAT_EN
            sat = 1'($urandom_range(0, 1));
`endif
            case (i % 10)
                0: beat(32'h7FFF_FFFF, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                1: beat(32'h8000_0000, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                2: beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
                default: beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            endcase
        end
        ready_chk = 1'b0;
        in_valid = 1'b0;
        drain();

        lat_chk = 1'b0;
        out_ready = 1'b0;
        a0 = accepts;
        for (int i = 0; i < 10; i++) begin
            beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        chk("bp_accepts", accepts - a0, N);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("bp_no_loss", outs, accepts);
        lat_chk = 1'b1;

        for (int i = 0; i < 6; i++) begin
            beat($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_S", S, 0);
        q.delete();
        held = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step();
        beat(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

`ifdef CLA_SAT_EN
        sat = 1'b1;
        beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        beat(32'h8000_0000, 32'h1, 1'b0, 1'b1);
        sat = 1'b0;
        beat(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        in_valid = 1'b0;
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined carry-lookahead adder built from 4-bit CLA groups with generate/propagate.
- Width is split into NSTAGE pipeline stages. Carry is registered between stages, so the adder closes timing at wide widths.
- Valid/ready handshake on the input and output sides.
- Used as the wide-add datapath element in the FA arithmetic library.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of 4*NSTAGE.
- NSTAGE, 4, number of pipeline stages; each stage adds WIDTH/NSTAGE bits using 4-bit CLA groups with group lookahead.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry in
- sub  input  1  1 = compute A-B (B inverted, carry forced to 1; Cin ignored)
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- S  output  WIDTH  sum/difference
- Cout  output  1  carry out of MSB (for subtraction: 1 = no borrow)
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid flags clear; out_valid=0, S=0, Cout=0, ovf=0.
  - in_ready reads 1 after reset deassertion.
- Pipeline stage k (0..NSTAGE-1):
  - adds slice k of A and B using the carry registered from stage k-1. Stage 0 uses Cin, or 1 when sub=1.
  - registers its sum slice, carry out and valid flag.
  - higher operand slices, not yet consumed, travel forward in delay registers with the beat.
- Latency: NSTAGE cycles from input accept to out_valid, with no stall.
- Throughput: 1 beat per cycle.
- Transfers:
  - input transfer = in_valid & in_ready.
  - output transfer = out_valid & out_ready.
- Backpressure (stage valid chain with per-stage enable):
  - stage k advances when stage k is empty, or when stage k+1 advances. The last stage advances on out_ready.
  - in_ready = stage 0 empty OR stage 0 advances this cycle. This is combinational from out_ready through the chain.
  - bubbles collapse: a held output does not block input while any earlier stage is empty.
- Stall: while out_valid=1 and out_ready=0, S, Cout and ovf hold stable and out_valid stays 1.
- Ordering: results emerge in input order. No beat is dropped or duplicated.
- Arithmetic:
  - S = (A + (sub ? ~B : B) + c0) mod 2^WIDTH; Cout = bit WIDTH of that sum.
  - ovf uses the MSB-1 carry from the final stage.
  - sub and Cin are sampled at input accept and travel with the beat.
- Simultaneous events:
  - With a full pipeline, out_ready=1 and in_valid=1, one beat exits and one enters in the same cycle.
  - out_ready low with the pipeline full drives in_ready=0.
- Reset mid-operation: in-flight beats are discarded; no out_valid pulse follows reset release until a new beat is accepted.
- Group carries inside a stage use full 4-group lookahead (P/G of groups), not ripple between groups.

Optional Feature:
- Macro: CLA_SAT_EN
- When defined:
  - extra input port sat (1 bit) travels with the beat.
  - when sat=1 and ovf=1, S is clamped to the signed limit: 0x7F..F for positive overflow, 0x80..0 for negative.
  - Cout and ovf are reported unmodified.
- When undefined: the port is absent and S always wraps modulo 2^WIDTH.

Test Plan:
- Single add: WIDTH=32, NSTAGE=4. A=0xFFFF_FFFF, B=1, Cin=0, out_ready=1 -> after 4 cycles S=0, Cout=1, ovf=0, out_valid high for 1 cycle.
- Subtract: A=5, B=7, sub=1 -> S=0xFFFF_FFFE, Cout=0. Then A=0x8000_0000, B=1, sub=1 -> S=0x7FFF_FFFF, ovf=1.
- Streaming: 100 random back-to-back beats with out_ready=1 -> one result per cycle, in order, matching the reference model; in_ready stays 1.
- Backpressure: fill the pipeline, then hold out_ready=0 for 10 cycles -> in_ready=0 after 4 accepts, S stable. Release -> no loss or duplication.
- Reset mid-stream: assert rst_n low with 3 beats in flight -> out_valid=0 immediately; after release, no stale results appear.
- CLA_SAT_EN defined: A=0x7FFF_FFFF, B=1, sat=1 -> S=0x7FFF_FFFF, ovf=1. Same stimulus with sat=0 -> S=0x8000_0000.
